// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, configurable parity/stop.
// Ports: clk, reset (sync, active-high); tx_data/tx_valid/tx_ready push side;
//   fifo_count queued words; transmitted_bit serial line (idle high);
//   tx_busy frame on line; frame_done 1-cycle pulse after last stop bit.
module uart_tx_fifo #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             transmitted_bit,
  output logic                             tx_busy,
  output logic                             frame_done
);
  localparam int D  = CLK_FREQUENCY / BAUD_RATE;
  localparam int CW = $clog2(2 * D);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(D - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * D - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  if (D < 2) begin : g_chk_d
    $fatal(1, "baud divider must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $fatal(1, "PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $fatal(1, "STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
    $fatal(1, "DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fd
    $fatal(1, "FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   par, par_n;
  logic                   line_n, done_n, pop, push, bit_end;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   head;

  assign tx_ready = (fifo_count < NW'(FIFO_DEPTH));
  assign push     = tx_valid & tx_ready;
  assign head     = mem[rd_ptr];
  assign bit_end  = (cnt == BIT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    pop     = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        cnt_n = cnt + CW'(1);
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_n = cnt + CW'(1);
        if (bit_end) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        cnt_n = cnt + CW'(1);
        if (bit_end) begin
          cnt_n   = '0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_n = cnt + CW'(1);
        if (cnt == STOP_LAST) begin
          cnt_n  = '0;
          done_n = 1'b1;
          // Chain straight into the next start bit when work is queued.
          if (fifo_count != '0) begin
            pop     = 1'b1;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Parity is latched with the word so the line bit is a plain register read.
  always_comb begin
    shreg_n = pop ? head : shreg;
    par_n   = pop ? ((^head) ^ (PARITY == 2)) : par;
    line_n  = 1'b1;
    unique case (state_n)
      ST_START:  line_n = 1'b0;
      ST_DATA:   line_n = shreg_n[idx_n];
      ST_PARITY: line_n = par_n;
      default:   line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      idx             <= '0;
      shreg           <= '0;
      par             <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      transmitted_bit <= 1'b1;
      tx_busy         <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      idx             <= idx_n;
      shreg           <= shreg_n;
      par             <= par_n;
      transmitted_bit <= line_n;
      tx_busy         <= (state_n != ST_IDLE);
      frame_done      <= done_n;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + NW'(1);
        2'b01:   fifo_count <= fifo_count - NW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule
